bcd_para_binario: RTL

// - Sequential BCD-to-binary converter using reverse double dabble: one shift-right/correct step per clock.
// - Inverse of the combinational binary-to-BCD display path.
// - Takes five BCD digits (00000..99999), for example from keypad or digit-entry logic, and returns an unsigned binary value.
// - Flags invalid digits and results that do not fit in the output width.

---
 rtl/bcd_para_binario.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bcd_para_binario.sv
// bcd_para_binario
// Sequential BCD-to-binary converter using reverse double dabble. The
// {bcd,acc} pair is shifted right by one bit per clock. After each shift,
// every BCD digit that is 8 or more is reduced by 3. After LARGURA
// iterations, acc holds the low LARGURA bits of the value. Any residue
// left in bcd means the value did not fit in LARGURA bits.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   iniciar        start request, sampled only while idle
//   dezenaDeMilhar BCD digit 10^4
//   milhar         BCD digit 10^3
//   centena        BCD digit 10^2
//   dezena         BCD digit 10^1
//   unidade        BCD digit 10^0
//   binario        result, held until the next pronto
//   ocupado        high while a conversion is in flight
//   pronto         one-cycle pulse when binario/erro are valid
//   erro           invalid digit or overflow, updated with pronto
//
// state    | meaning
// ---------+---------------------------------------------------------
// OCIOSO   | idle, waiting for iniciar
// CONVERTE | one shift/correct iteration per cycle
// CONCLUI  | publish binario/erro and pulse pronto
module bcd_para_binario #(
    parameter int LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iniciar,
    input  logic [3:0]         dezenaDeMilhar,
    input  logic [3:0]         milhar,
    input  logic [3:0]         centena,
    input  logic [3:0]         dezena,
    input  logic [3:0]         unidade,
    output logic [LARGURA-1:0] binario,
    output logic               ocupado,
    output logic               pronto,
    output logic               erro
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        CONCLUI  = 2'd2
    } estado_t;

    estado_t             estado;
    estado_t             proximo;

    logic [19:0]         bcd;
    logic [LARGURA-1:0]  acc;
    logic [CW-1:0]       cnt;
    logic                invalido;

    logic [19:0]         entrada;
    logic                digito_invalido;
    logic [LARGURA+19:0] desloc;
    logic [19:0]         bcd_corr;
    logic                ocupado_prox;
    logic                pronto_prox;

    assign entrada = {dezenaDeMilhar, milhar, centena, dezena, unidade};

    always_comb begin
        digito_invalido = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (entrada[4*i +: 4] > 4'd9) begin
                digito_invalido = 1'b1;
            end
        end
    end

    // Shift and digit correction happen in the same cycle. A digit that
    // received the shifted-in bit from the digit above gains 8 where it
    // should gain 5, so it is corrected by subtracting 3.
    assign desloc = {bcd, acc} >> 1;

    always_comb begin
        bcd_corr = desloc[LARGURA +: 20];
        for (int i = 0; i < 5; i++) begin
            if (bcd_corr[4*i +: 4] >= 4'd8) begin
                bcd_corr[4*i +: 4] = bcd_corr[4*i +: 4] - 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    proximo = digito_invalido ? CONCLUI : CONVERTE;
                end
            end
            CONVERTE: begin
                if (cnt == ULTIMO) begin
                    proximo = CONCLUI;
                end
            end
            CONCLUI: begin
                proximo = OCIOSO;
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    // Output decode. The result is registered below so that the outputs
    // never depend combinationally on the inputs.
    always_comb begin
        ocupado_prox = (proximo != OCIOSO);
        pronto_prox  = (estado == CONCLUI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd      <= '0;
            acc      <= '0;
            cnt      <= '0;
            invalido <= 1'b0;
            binario  <= '0;
            erro     <= 1'b0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            ocupado <= ocupado_prox;
            pronto  <= pronto_prox;
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        bcd      <= entrada;
                        acc      <= '0;
                        cnt      <= '0;
                        invalido <= digito_invalido;
                    end
                end
                CONVERTE: begin
                    bcd <= bcd_corr;
                    acc <= desloc[LARGURA-1:0];
                    cnt <= cnt + CW'(1);
                end
                CONCLUI: begin
                    // On overflow acc already holds the truncated low bits.
                    binario <= invalido ? '0 : acc;
                    erro    <= invalido | (bcd != 20'd0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
